// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM: opcodes, state enum and datapath selects.
// The TRAP state only exists when MAIN_FSM_TRAP_EN is defined.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
`ifdef MAIN_FSM_TRAP_EN
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
`else
        S_BEQ      = 4'd10
`endif
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011
    } imm_src_e;

    // Immediate format follows the opcode directly, independent of FSM state.
    function automatic imm_src_e imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory accesses; expired marks the cycle the count reaches TIMEOUT_MAX.
// TIMEOUT_MAX of 0 keeps the counter at zero and never expires.
module mem_wait_timer #(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic wait_en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_MAX);

    logic [TIMEOUT_W-1:0] count_d;
    logic [TIMEOUT_W-1:0] count_q;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (wait_en && (count_q != LIMIT)) begin
            count_d = count_q + TIMEOUT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT_MAX != 0) && (count_q == LIMIT);

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM with a memory-wait timeout that raises bus_err.
// Define MAIN_FSM_TRAP_EN to route unknown opcodes through a TRAP state that pulses illegal_instr.
module main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       bus_err,
    output logic       illegal_instr
);

    state_e state_d;
    state_e state_q;

    logic timer_clear;
    logic timer_wait;
    logic timer_expired;
    logic timed_out;

    // An expiry only counts when the memory has not answered in that same cycle.
    assign timed_out = is_mem_wait(state_q) && timer_expired && !mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timed_out) state_d = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
`ifdef MAIN_FSM_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LOAD)       state_d = S_MEMREAD;
                else if (op == OP_STORE) state_d = S_MEMWRITE;
                else                     state_d = S_FETCH;
            end
            S_MEMREAD: begin
                if (mem_ready)      state_d = S_MEMWB;
                else if (timed_out) state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                if (mem_ready || timed_out) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
`ifdef MAIN_FSM_TRAP_EN
            S_TRAP:                  state_d = S_FETCH;
`endif
            default:                 state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Re-arm on every entry to a wait state, including FETCH re-entered after a timeout.
    assign timer_clear = is_mem_wait(state_d) && ((state_d != state_q) || timed_out);
    assign timer_wait  = is_mem_wait(state_q) && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_MAX (TIMEOUT_MAX)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset_n),
        .clear   (timer_clear),
        .wait_en (timer_wait),
        .expired (timer_expired)
    );

    always_comb begin
        mem_req   = 1'b0;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_SUB;
                PCWrite = zero;
            end
            default: ;
        endcase

        // An abandoned access must not commit anything to PC, IR or memory.
        if (timed_out) begin
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
        end
        if (!reset_n) begin
            mem_req = 1'b0;
            PCWrite = 1'b0;
            IRWrite = 1'b0;
        end
    end

    assign bus_err = reset_n && timed_out;
    assign ImmSrc  = imm_src_of(op);

`ifdef MAIN_FSM_TRAP_EN
    assign illegal_instr = reset_n && (state_q == S_TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: the driver queues expected outputs per cycle, a monitor checks them.
// Built with TIMEOUT_MAX=4; the TRAP path is exercised when MAIN_FSM_TRAP_EN is defined.
module tb_main_fsm;

    localparam int TMAX = 4;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;
    localparam logic [6:0] OP_X = 7'b1111111;

    typedef enum int {
        P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
        P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BEQ, P_TRAP
    } phase_t;

    typedef struct {
        logic [18:0] vec;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       bus_err, illegal_instr;

    logic [18:0] act;
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    main_fsm #(
        .TIMEOUT_W   (8),
        .TIMEOUT_MAX (TMAX)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .op            (op),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .PCWrite       (PCWrite),
        .IRWrite       (IRWrite),
        .AdrSrc        (AdrSrc),
        .MemWrite      (MemWrite),
        .RegWrite      (RegWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .ImmSrc        (ImmSrc),
        .bus_err       (bus_err),
        .illegal_instr (illegal_instr)
    );

    assign act = {mem_req, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, bus_err, illegal_instr};

    // Expected outputs for one cycle, written straight from the control table.
    function automatic logic [18:0] expect_vec(input phase_t p, input logic [6:0] o,
                                               input logic mr, input logic z, input logic expire);
        logic       mreq, pcw, irw, adr, mw, rw, be, ill;
        logic [1:0] rs, sa, sb, aop;
        logic [2:0] imm;
        mreq = 0; pcw = 0; irw = 0; adr = 0; mw = 0; rw = 0; be = 0; ill = 0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
        case (o)
            OP_S:    imm = 3'b001;
            OP_B:    imm = 3'b010;
            OP_J:    imm = 3'b011;
            default: imm = 3'b000;
        endcase
        case (p)
            P_RESET:    begin sb = 2'b10; rs = 2'b10; end
            P_FETCH:    begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            P_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            P_MEMREAD:  begin mreq = 1; adr = 1; end
            P_MEMWB:    begin rs = 2'b01; rw = 1; end
            P_MEMWRITE: begin mreq = 1; adr = 1; mw = 1; end
            P_EXECR:    begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
            P_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            P_ALUWB:    begin rs = 2'b00; rw = 1; end
            P_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            P_BEQ:      begin sa = 2'b10; sb = 2'b00; aop = 2'b01; pcw = z; end
            P_TRAP:     begin ill = 1; end
            default:    ;
        endcase
        if (expire) begin
            be = 1; mw = 0; irw = 0; pcw = 0;
        end
        return {mreq, pcw, irw, adr, mw, rw, rs, sa, sb, aop, imm, be, ill};
    endfunction

    // Drive one cycle's inputs just after the edge and queue what the DUT must show in that cycle.
    task automatic cyc(input phase_t p, input logic [6:0] o, input logic mr,
                       input logic z, input logic expire, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n   = (p != P_RESET);
        op        = o;
        mem_ready = mr;
        zero      = z;
        e.vec = expect_vec(p, o, mr, z, expire);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e.vec) begin
                    errors++;
                    $display("FAIL %s got %b want %b", e.tag, act, e.vec);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        reset_n   = 1'b0;
        op        = OP_R;
        zero      = 1'b0;
        mem_ready = 1'b1;

        cyc(P_RESET, OP_R, 1, 0, 0, "reset0");
        cyc(P_RESET, OP_R, 1, 0, 0, "reset1");

        cyc(P_FETCH,  OP_R, 1, 0, 0, "r_fetch");
        cyc(P_DECODE, OP_R, 1, 0, 0, "r_decode");
        cyc(P_EXECR,  OP_R, 1, 0, 0, "r_execr");
        cyc(P_ALUWB,  OP_R, 1, 0, 0, "r_aluwb");

        cyc(P_FETCH,  OP_L, 1, 0, 0, "ld_fetch");
        cyc(P_DECODE, OP_L, 1, 0, 0, "ld_decode");
        cyc(P_MEMADR, OP_L, 1, 0, 0, "ld_memadr");
        for (int i = 0; i < 3; i++) cyc(P_MEMREAD, OP_L, 0, 0, 0, "ld_wait");
        cyc(P_MEMREAD, OP_L, 1, 0, 0, "ld_ready");
        cyc(P_MEMWB,   OP_L, 1, 0, 0, "ld_memwb");

        cyc(P_FETCH,  OP_S, 1, 0, 0, "st_fetch");
        cyc(P_DECODE, OP_S, 1, 0, 0, "st_decode");
        cyc(P_MEMADR, OP_S, 1, 0, 0, "st_memadr");
        for (int i = 0; i < TMAX; i++) cyc(P_MEMWRITE, OP_S, 0, 0, 0, "st_wait");
        cyc(P_MEMWRITE, OP_S, 0, 0, 1, "st_expire");

        cyc(P_FETCH,  OP_S, 1, 0, 0, "st2_fetch");
        cyc(P_DECODE, OP_S, 1, 0, 0, "st2_decode");
        cyc(P_MEMADR, OP_S, 1, 0, 0, "st2_memadr");
        for (int i = 0; i < TMAX; i++) cyc(P_MEMWRITE, OP_S, 0, 0, 0, "st2_wait");
        cyc(P_MEMWRITE, OP_S, 1, 0, 0, "st2_late_ready");

        cyc(P_FETCH,  OP_B, 1, 1, 0, "beq1_fetch");
        cyc(P_DECODE, OP_B, 1, 1, 0, "beq1_decode");
        cyc(P_BEQ,    OP_B, 1, 1, 0, "beq_taken");
        cyc(P_FETCH,  OP_B, 1, 0, 0, "beq0_fetch");
        cyc(P_DECODE, OP_B, 1, 0, 0, "beq0_decode");
        cyc(P_BEQ,    OP_B, 1, 0, 0, "beq_not_taken");

        cyc(P_FETCH,  OP_J, 1, 0, 0, "jal_fetch");
        cyc(P_DECODE, OP_J, 1, 0, 0, "jal_decode");
        cyc(P_JAL,    OP_J, 1, 0, 0, "jal_state");
        cyc(P_ALUWB,  OP_J, 1, 0, 0, "jal_aluwb");

        cyc(P_FETCH,  OP_I, 1, 0, 0, "i_fetch");
        cyc(P_DECODE, OP_I, 1, 0, 0, "i_decode");
        cyc(P_EXECI,  OP_I, 1, 0, 0, "i_execi");
        cyc(P_ALUWB,  OP_I, 1, 0, 0, "i_aluwb");

        cyc(P_FETCH,  OP_X, 1, 0, 0, "ill_fetch");
        cyc(P_DECODE, OP_X, 1, 0, 0, "ill_decode");
`ifdef MAIN_FSM_TRAP_EN
        cyc(P_TRAP,   OP_X, 1, 0, 0, "ill_trap");
`endif

        cyc(P_FETCH,  OP_L, 1, 0, 0, "rst_fetch");
        cyc(P_DECODE, OP_L, 1, 0, 0, "rst_decode");
        cyc(P_MEMADR, OP_L, 1, 0, 0, "rst_memadr");
        for (int i = 0; i < 3; i++) cyc(P_MEMREAD, OP_L, 0, 0, 0, "rst_wait");
        cyc(P_RESET, OP_L, 1, 0, 0, "rst_abandon");
        for (int i = 0; i < TMAX; i++) cyc(P_FETCH, OP_L, 0, 0, 0, "rst_fresh_wait");
        cyc(P_FETCH,  OP_L, 0, 0, 1, "fetch_expire");
        cyc(P_FETCH,  OP_L, 1, 0, 0, "fetch_after_expire");
        cyc(P_DECODE, OP_L, 1, 0, 0, "final_decode");

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
